// File: rtl/uart_tx_line_arbiter_if.sv
// Bundle of the serial lines and status flags between the two serial
// sources, the uart_tx line arbiter and the board pin.
// master : drives the two source lines and the diagnostic request.
// slave  : the arbiter; drives the pin, the grant and the status outputs.
interface uart_tx_line_arbiter_if;
  logic       cpu_sout;
  logic       hw_sout;
  logic       hw_req;
  logic       hw_gnt;
  logic       uart_tx;
  logic       owner_hw;
  logic [7:0] cpu_lost_cnt;
  logic       hw_timeout;

  modport master (
    output cpu_sout,
    output hw_sout,
    output hw_req,
    input  hw_gnt,
    input  uart_tx,
    input  owner_hw,
    input  cpu_lost_cnt,
    input  hw_timeout
  );

  modport slave (
    input  cpu_sout,
    input  hw_sout,
    input  hw_req,
    output hw_gnt,
    output uart_tx,
    output owner_hw,
    output cpu_lost_cnt,
    output hw_timeout
  );
endinterface

// File: rtl/uart_tx_line_arbiter.sv
// uart_tx_line_arbiter
// Shares the board uart_tx pin between the 16550 console output (cpu_sout)
// and the diagnostic beacon (hw_sout). Ownership only moves after the
// current owner's line has been idle (mark) for a whole frame gap, so no
// character is ever cut. The CPU always gets the line back between bursts.
// Optional feature: define UART_ARB_TIMEOUT_EN to bound how long the
// diagnostic source may keep the grant (HOLD_MAX_CYC cycles).
module uart_tx_line_arbiter #(
  parameter int BIT_CYC      = 434,
  parameter int IDLE_BITS    = 12,
  parameter int HOLD_MAX_CYC = 50000000
) (
  input  logic             clk_50,
  input  logic             fpga_reset_n,
  uart_tx_line_arbiter_if.slave bus
);

  localparam int GAP    = BIT_CYC * IDLE_BITS;
  localparam int IDLE_W = $clog2(GAP + 1);
  localparam logic [IDLE_W-1:0] GAP_V = IDLE_W'(GAP);

  // A zero or negative hold limit would make the forced release meaningless.
  if (HOLD_MAX_CYC < 1) begin : g_hold_param_err
    $error("uart_tx_line_arbiter: HOLD_MAX_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    WAIT_GAP = 2'd1,
    HW_OWN   = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic              mon_line_s;
  logic              gap_ok_s;
  logic              timeout_hit_s;
  logic              hw_gnt_r;
  logic              owner_hw_r;
  logic              uart_tx_r;
  logic              cpu_prev_r;
  logic [7:0]        cpu_lost_cnt_r;

  // The idle gap is measured on whichever line currently owns (or is about
  // to give up) the pin.
  always_comb begin
    mon_line_s = bus.cpu_sout;
    case (state_r)
      CPU_OWN,
      WAIT_GAP: mon_line_s = bus.cpu_sout;
      HW_OWN,
      RELEASE:  mon_line_s = bus.hw_sout;
      default:  mon_line_s = bus.cpu_sout;
    endcase
  end

  assign gap_ok_s = (idle_cnt_r == GAP_V);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX_CYC - 1);

  logic [HOLD_W-1:0] hold_cnt_r;
  logic              hw_timeout_r;

  // The forced release fires on the cycle that completes HOLD_MAX_CYC
  // cycles of diagnostic ownership.
  assign timeout_hit_s = (state_r == HW_OWN) && (hold_cnt_r == HOLD_LAST);

  // Count cycles spent in HW_OWN; any entry into or exit from it restarts.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else if ((state_r == HW_OWN) && (state_next_s == HW_OWN)) begin
      hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
    end else begin
      hold_cnt_r <= {HOLD_W{1'b0}};
    end
  end

  // One-cycle flag only when the release was forced, not requested.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      hw_timeout_r <= 1'b0;
    end else begin
      hw_timeout_r <= timeout_hit_s & bus.hw_req;
    end
  end

  assign bus.hw_timeout = hw_timeout_r;
`else
  assign timeout_hit_s  = 1'b0;
  assign bus.hw_timeout = 1'b0;
`endif

  // Ownership state register.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      state_r <= CPU_OWN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. A request drop in WAIT_GAP beats a simultaneous gap,
  // and requests seen in RELEASE wait until the CPU has the line again.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CPU_OWN: begin
        if (bus.hw_req) begin
          state_next_s = WAIT_GAP;
        end else begin
          state_next_s = CPU_OWN;
        end
      end
      WAIT_GAP: begin
        if (!bus.hw_req) begin
          state_next_s = CPU_OWN;
        end else if (gap_ok_s) begin
          state_next_s = HW_OWN;
        end else begin
          state_next_s = WAIT_GAP;
        end
      end
      HW_OWN: begin
        if (!bus.hw_req || timeout_hit_s) begin
          state_next_s = RELEASE;
        end else begin
          state_next_s = HW_OWN;
        end
      end
      RELEASE: begin
        if (gap_ok_s) begin
          state_next_s = CPU_OWN;
        end else begin
          state_next_s = RELEASE;
        end
      end
      default: state_next_s = CPU_OWN;
    endcase
  end

  // Consecutive-mark counter on the monitored line, saturating at the gap
  // and restarted on every ownership state change.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end else if (state_next_s != state_r) begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end else if (!mon_line_s) begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end else if (!gap_ok_s) begin
      idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  // Grant and owner flags follow the state being entered, so they rise in
  // the same cycle the state becomes HW_OWN.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      hw_gnt_r   <= 1'b0;
      owner_hw_r <= 1'b0;
    end else begin
      hw_gnt_r   <= (state_next_s == HW_OWN);
      owner_hw_r <= (state_next_s == HW_OWN) || (state_next_s == RELEASE);
    end
  end

  // Registered pin mux; both lines are idle whenever owner_hw flips, so the
  // pin cannot dip low at a handover.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      uart_tx_r <= 1'b1;
    end else if (owner_hw_r) begin
      uart_tx_r <= bus.hw_sout;
    end else begin
      uart_tx_r <= bus.cpu_sout;
    end
  end

  // Count CPU start bits (falling edges) that were dropped because the
  // diagnostic source owned the pin; saturates and only reset clears it.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      cpu_prev_r     <= 1'b1;
      cpu_lost_cnt_r <= 8'd0;
    end else begin
      cpu_prev_r <= bus.cpu_sout;
      if (owner_hw_r && cpu_prev_r && !bus.cpu_sout && (cpu_lost_cnt_r != 8'hFF)) begin
        cpu_lost_cnt_r <= cpu_lost_cnt_r + 8'd1;
      end else begin
        cpu_lost_cnt_r <= cpu_lost_cnt_r;
      end
    end
  end

  assign bus.hw_gnt       = hw_gnt_r;
  assign bus.owner_hw     = owner_hw_r;
  assign bus.uart_tx      = uart_tx_r;
  assign bus.cpu_lost_cnt = cpu_lost_cnt_r;

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Self-checking bench for uart_tx_line_arbiter: a short vector table for
// single-cycle behaviour plus hand-written sequences for the frame-gap
// handovers, release, lost-start counting, reset and the hold timeout.
`timescale 1ns/1ps
module tb_uart_tx_line_arbiter;

  localparam int BIT_CYC = 434;
  localparam int IDLE_BITS = 12;
  localparam int GAP = BIT_CYC * IDLE_BITS;
  localparam int HOLD = 1000;

  logic clk_50 = 1'b0;
  logic fpga_reset_n;

  uart_tx_line_arbiter_if bus ();

  uart_tx_line_arbiter #(
    .BIT_CYC     (BIT_CYC),
    .IDLE_BITS   (IDLE_BITS),
    .HOLD_MAX_CYC(HOLD)
  ) dut (
    .clk_50      (clk_50),
    .fpga_reset_n(fpga_reset_n),
    .bus         (bus)
  );

  always #10 clk_50 = ~clk_50;

  int tests_run = 0;
  int tests_failed = 0;

  // Pin monitor: uart_tx must equal the expected owner's line one cycle late.
  logic mon_en = 1'b0;
  logic exp_own_hw = 1'b0;
  logic last_cpu = 1'b1;
  logic last_hw = 1'b1;
  int   tx_err = 0;

  always @(posedge clk_50) begin
    last_cpu <= bus.cpu_sout;
    last_hw  <= bus.hw_sout;
  end

  always @(negedge clk_50) begin
    if (mon_en && (bus.uart_tx !== (exp_own_hw ? last_hw : last_cpu))) tx_err++;
  end

  typedef struct {
    logic cpu;
    logic hw;
    logic req;
    logic tx;
    logic gnt;
    logic own;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic set_line(input bit to_hw, input logic v);
    if (to_hw) bus.hw_sout = v;
    else       bus.cpu_sout = v;
  endtask

  // 8N1 frame, LSB first; the stop bit is optional so a caller can time
  // the idle gap from its first cycle.
  task automatic send_frame(input bit to_hw, input logic [7:0] data, input bit with_stop);
    set_line(to_hw, 1'b0);
    tick(BIT_CYC);
    for (int b = 0; b < 8; b++) begin
      set_line(to_hw, data[b]);
      tick(BIT_CYC);
    end
    if (with_stop) begin
      set_line(to_hw, 1'b1);
      tick(BIT_CYC);
    end
  endtask

  // Hard time bound in case the run gets stuck.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    logic        gnt_seen;
    logic        found;
    int          bad;

    vecs[0] = '{cpu:1'b0, hw:1'b1, req:1'b0, tx:1'b0, gnt:1'b0, own:1'b0};
    vecs[1] = '{cpu:1'b1, hw:1'b0, req:1'b0, tx:1'b1, gnt:1'b0, own:1'b0};
    vecs[2] = '{cpu:1'b0, hw:1'b0, req:1'b1, tx:1'b0, gnt:1'b0, own:1'b0};
    vecs[3] = '{cpu:1'b1, hw:1'b0, req:1'b0, tx:1'b1, gnt:1'b0, own:1'b0};
    vecs[4] = '{cpu:1'b0, hw:1'b1, req:1'b0, tx:1'b0, gnt:1'b0, own:1'b0};
    vecs[5] = '{cpu:1'b1, hw:1'b0, req:1'b1, tx:1'b1, gnt:1'b0, own:1'b0};
    vecs[6] = '{cpu:1'b1, hw:1'b1, req:1'b1, tx:1'b1, gnt:1'b0, own:1'b0};
    vecs[7] = '{cpu:1'b0, hw:1'b1, req:1'b1, tx:1'b0, gnt:1'b0, own:1'b0};

    fpga_reset_n = 1'b0;
    bus.cpu_sout = 1'b1;
    bus.hw_sout  = 1'b1;
    bus.hw_req   = 1'b0;
    tick(3);

    // Reset values
    check("rst_uart_tx", bus.uart_tx, 1);
    check("rst_hw_gnt", bus.hw_gnt, 0);
    check("rst_owner_hw", bus.owner_hw, 0);
    check("rst_lost_cnt", bus.cpu_lost_cnt, 0);
    check("rst_hw_timeout", bus.hw_timeout, 0);
    fpga_reset_n = 1'b1;
    tick(2);

    // Single-cycle behaviour while the CPU owns the pin
    for (int i = 0; i < 8; i++) begin
      bus.cpu_sout = vecs[i].cpu;
      bus.hw_sout  = vecs[i].hw;
      bus.hw_req   = vecs[i].req;
      tick(1);
      check($sformatf("vec%0d_tx", i), bus.uart_tx, vecs[i].tx);
      check($sformatf("vec%0d_gnt", i), bus.hw_gnt, vecs[i].gnt);
      check($sformatf("vec%0d_own", i), bus.owner_hw, vecs[i].own);
    end
    check("tbl_lost_cnt", bus.cpu_lost_cnt, 0);
    bus.cpu_sout = 1'b1;
    bus.hw_sout  = 1'b1;
    bus.hw_req   = 1'b0;
    tick(2);

    // Idle handover: grant lands GAP+1 cycles after the request is sampled
    bus.hw_req = 1'b1;
    tick(GAP + 1);
    check("idle_gnt_early", bus.hw_gnt, 0);
    tick(1);
    check("idle_gnt", bus.hw_gnt, 1);
    check("idle_owner", bus.owner_hw, 1);
    exp_own_hw = 1'b1;
    tx_err = 0;
    mon_en = 1'b1;
    pat = 16'b1010_0110_0011_1101;
    for (int i = 0; i < 16; i++) begin
      bus.hw_sout = pat[i];
      tick(1);
    end
    bus.hw_sout = 1'b1;
    tick(1);
    check("hw_follow_tx", tx_err, 0);

    // CPU start bits while the diagnostic source owns the pin
    for (int i = 0; i < 300; i++) begin
      bus.cpu_sout = 1'b0;
      tick(2);
      bus.cpu_sout = 1'b1;
      tick(2);
      if (i == 253) check("lost_cnt_254", bus.cpu_lost_cnt, 254);
    end
    check("lost_cnt_sat", bus.cpu_lost_cnt, 255);
    check("lost_tx_clean", tx_err, 0);
    check("lost_owner", bus.owner_hw, 1);

    // Asynchronous reset in the middle of HW ownership
    mon_en = 1'b0;
    bus.hw_sout = 1'b0;
    tick(2);
    check("pre_rst_tx", bus.uart_tx, 0);
    fpga_reset_n = 1'b0;
    #1;
    check("mid_rst_tx", bus.uart_tx, 1);
    check("mid_rst_gnt", bus.hw_gnt, 0);
    check("mid_rst_owner", bus.owner_hw, 0);
    check("mid_rst_lost", bus.cpu_lost_cnt, 0);
    bus.hw_sout = 1'b1;
    bus.hw_req  = 1'b0;
    tick(2);
    fpga_reset_n = 1'b1;
    tick(2);

    // Busy CPU: grant waits for a full gap after the last frame's stop bit
    exp_own_hw = 1'b0;
    tx_err = 0;
    mon_en = 1'b1;
    bus.hw_req = 1'b1;
    send_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'h55, 1'b0);
    check("busy_gnt_in_frame", bus.hw_gnt, 0);
    bus.cpu_sout = 1'b1;
    tick(GAP);
    check("busy_gnt_early", bus.hw_gnt, 0);
    tick(1);
    check("busy_gnt", bus.hw_gnt, 1);
    check("busy_no_trunc", tx_err, 0);
    exp_own_hw = 1'b1;

    // Release and return to the CPU
    send_frame(1'b1, 8'hA5, 1'b1);
    send_frame(1'b1, 8'h3C, 1'b1);
    send_frame(1'b1, 8'h0F, 1'b1);
    check("hw_bytes_tx", tx_err, 0);
    bus.hw_req = 1'b0;
    tick(1);
    check("rel_gnt_drop", bus.hw_gnt, 0);
    check("rel_owner_kept", bus.owner_hw, 1);
    gnt_seen = 1'b0;
    for (int j = 2; j <= GAP + 1; j++) begin
      tick(1);
      if (bus.hw_gnt) gnt_seen = 1'b1;
      if (j == 100) bus.hw_req = 1'b1;
    end
    check("rel_owner_held", bus.owner_hw, 1);
    check("rel_req_ignored", gnt_seen, 0);
    tick(1);
    check("rel_owner_back", bus.owner_hw, 0);
    check("rel_gnt_after", bus.hw_gnt, 0);
    check("rel_tx_clean", tx_err, 0);
    mon_en = 1'b0;

    // Re-grant (request still high), then hold with the request asserted
    found = 1'b0;
    for (int k = 0; k < GAP + 10 && !found; k++) begin
      tick(1);
      if (bus.hw_gnt) found = 1'b1;
    end
    check("regrant", found, 1);
    bad = 0;
    for (int k = 1; k < HOLD; k++) begin
      tick(1);
      if (!bus.hw_gnt || bus.hw_timeout) bad++;
    end
    check("hold_window", bad, 0);
    tick(1);
`ifdef UART_ARB_TIMEOUT_EN
    check("to_gnt_drop", bus.hw_gnt, 0);
    check("to_pulse", bus.hw_timeout, 1);
    tick(1);
    check("to_pulse_end", bus.hw_timeout, 0);
`else
    check("no_to_gnt", bus.hw_gnt, 1);
    check("no_to_pulse", bus.hw_timeout, 0);
    tick(1);
    check("no_to_pulse_next", bus.hw_timeout, 0);
    check("no_to_gnt_next", bus.hw_gnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
